// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 make/break/E0 byte sequences into held-key state,
// press pulses with auto-repeat, and a make/break event FIFO with valid/ready.
module ps2_key_tracker #(
    parameter int NUM_KEYS = 8,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {9'h172, 9'h175, 9'h02D, 9'h029,
                                                  9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE = 5_000_000,
    parameter int FIFO_DEPTH = 8,
    localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic [7:0]          scan_code,
    input  logic                scan_ready,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                evt_valid,
    output logic [KW:0]         evt_data,
    input  logic                evt_ready,
    output logic                evt_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t            state;
    logic              is_ext, is_brk, fin, hit, make_new, brk_held, rep_fire;
    logic [KW-1:0]     idx, tgt;
    logic              armed;
    logic [31:0]       cnt;
    logic              pend_v;
    logic [KW:0]       pend_d;
    logic [KW:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       count;
    logic              full, pop, wr;

    assign is_ext = state == EXT || state == EXT_BRK;
    assign is_brk = state == BRK || state == EXT_BRK;
    assign fin = scan_ready && scan_code != 8'hE0 && scan_code != 8'hF0;

    // Descending scan so the lowest matching table index wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (KEY_CODES[9*i +: 9] == {is_ext, scan_code}) begin
                hit = 1'b1;
                idx = KW'(i);
            end
    end

    assign make_new = fin && hit && !is_brk && !key_held[idx];
    assign brk_held = fin && hit && is_brk && key_held[idx];
    assign rep_fire = armed && cnt == 32'd1 && key_held[tgt] && !make_new;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (scan_ready)
            state <= scan_code == 8'hE0 ? (is_brk ? EXT_BRK : EXT) :
                     scan_code == 8'hF0 ? (is_ext ? EXT_BRK : BRK) : IDLE;
    end

    // The event is staged one cycle so evt_valid trails key_held by a cycle.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            armed       <= 1'b0;
            tgt         <= '0;
            cnt         <= '0;
            pend_v      <= 1'b0;
            pend_d      <= '0;
        end else begin
            key_press   <= (make_new ? NUM_KEYS'(1) << idx : '0) | (rep_fire ? NUM_KEYS'(1) << tgt : '0);
            key_release <= brk_held ? NUM_KEYS'(1) << idx : '0;
            if (make_new)
                key_held[idx] <= 1'b1;
            else if (brk_held)
                key_held[idx] <= 1'b0;
            pend_v <= make_new || brk_held;
            pend_d <= {make_new, idx};
            if (make_new) begin
                armed <= REPEAT_DELAY != 0;
                tgt   <= idx;
                cnt   <= 32'(REPEAT_DELAY);
            end else if (brk_held && idx == tgt) begin
                armed <= 1'b0;
                cnt   <= '0;
            end else if (armed)
                cnt <= cnt == 32'd1 ? 32'(REPEAT_RATE) : cnt - 32'd1;
        end
    end

    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign evt_valid = count != '0;
    assign pop       = evt_valid && evt_ready;
    assign wr        = pend_v && (!full || pop);
    assign evt_data  = evt_valid ? mem[rp] : '0;

    always_ff @(posedge CLOCK_50)
        if (wr)
            mem[wp] <= pend_d;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            wp    <= wp + AW'(wr);
            rp    <= rp + AW'(pop);
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
            if (pend_v && full && !pop)
                evt_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed checks of decode, auto-repeat, handoff, FIFO limits and reset,
// with an event scoreboard queue popped as the consumer drains the FIFO.
module tb_ps2_key_tracker;
    logic       CLOCK_50 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_ready = 1'b0;
    logic       evt_ready = 1'b0;
    logic [7:0] key_held, key_press, key_release;
    logic       evt_valid, evt_overflow;
    logic [3:0] evt_data;

    int total = 0;
    int bad = 0;
    logic [3:0] exp_q[$];
    logic [63:0] m0, m1, e1;
    int p;

    ps2_key_tracker #(.REPEAT_DELAY(20), .REPEAT_RATE(5), .FIFO_DEPTH(4)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .scan_code(scan_code), .scan_ready(scan_ready),
        .key_held(key_held), .key_press(key_press), .key_release(key_release),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .evt_overflow(evt_overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        scan_code = b;
        scan_ready = 1'b1;
        @(negedge CLOCK_50);
        scan_ready = 1'b0;
    endtask

    task automatic drain();
        int n = exp_q.size();
        int got = 0;
        int t = 0;
        evt_ready = 1'b1;
        while (got < n && t < 60) begin
            if (evt_valid) begin
                chk("evt_data", evt_data, exp_q.pop_front());
                got++;
            end
            @(negedge CLOCK_50);
            t++;
        end
        evt_ready = 1'b0;
        chk("drain_count", got, n);
        chk("drain_empty", evt_valid, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        idle(2);
        chk("rst_held", key_held, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_ovf", evt_overflow, 0);
        @(negedge CLOCK_50) rst = 1'b0;

        // make/break of W
        send(8'h1D); exp_q.push_back(4'h8);
        chk("mk_held", key_held, 8'h01);
        chk("mk_press", key_press, 8'h01);
        chk("mk_valid_lat", evt_valid, 0);
        idle(1);
        chk("mk_valid_lat2", evt_valid, 1);
        chk("mk_press_width", key_press, 0);
        send(8'hF0); send(8'h1D); exp_q.push_back(4'h0);
        chk("bk_held", key_held, 0);
        chk("bk_release", key_release, 8'h01);
        drain();

        // extended codes
        send(8'h1D); exp_q.push_back(4'h8);
        send(8'hE0); send(8'h75); exp_q.push_back(4'hE);
        chk("ext_up", key_held, 8'h41);
        send(8'h75);
        chk("plain_75", key_held, 8'h41);
        send(8'hE0); send(8'hF0); send(8'h75); exp_q.push_back(4'h6);
        chk("ext_up_brk", key_held, 8'h01);
        drain();
        send(8'hE0); send(8'h72); exp_q.push_back(4'hF);
        chk("ext_down", key_held, 8'h81);
        send(8'hF0); send(8'hE0); send(8'h72); exp_q.push_back(4'h7);
        chk("f0e0_down_brk", key_held, 8'h01);
        send(8'hF0); send(8'h1D); exp_q.push_back(4'h0);
        drain();

        // auto-repeat of Space with keyboard typematic bytes interleaved
        send(8'h29); exp_q.push_back(4'hC);
        m0 = '0;
        for (int k = 0; k < 40; k++) begin
            m0[k] = key_press[4];
            scan_code = 8'h29;
            scan_ready = (k == 8 || k == 13);
            @(negedge CLOCK_50);
        end
        scan_ready = 1'b0;
        chk("repeat_pulses", m0, 64'h0000_0008_4210_0001);
        send(8'hF0); send(8'h29); exp_q.push_back(4'h4);
        chk("rep_release", key_release, 8'h10);
        p = 0;
        for (int k = 0; k < 30; k++) begin
            p += $countones(key_press);
            @(negedge CLOCK_50);
        end
        chk("rep_stopped", p, 0);
        drain();

        // target handoff W -> A
        send(8'h1D); exp_q.push_back(4'h8);
        m0 = '0; m1 = '0;
        for (int k = 0; k < 60; k++) begin
            m0[k] = key_press[0];
            m1[k] = key_press[1];
            scan_code = 8'h1C;
            scan_ready = (k == 10);
            @(negedge CLOCK_50);
        end
        scan_ready = 1'b0;
        exp_q.push_back(4'h9);
        e1 = '0;
        e1[11] = 1'b1;
        for (int j = 31; j < 60; j += 5) e1[j] = 1'b1;
        chk("handoff_w", m0, 64'h1);
        chk("handoff_a", m1, e1);
        send(8'hF0); send(8'h1C); exp_q.push_back(4'h1);
        chk("handoff_rel", key_release, 8'h02);
        p = 0;
        for (int k = 0; k < 40; k++) begin
            p += $countones(key_press);
            @(negedge CLOCK_50);
        end
        chk("handoff_stop", p, 0);
        chk("handoff_w_held", key_held, 8'h01);
        drain();

        // FIFO full / overflow / simultaneous push+pop
        send(8'hF0); send(8'h1D); exp_q.push_back(4'h0);
        send(8'h1D); exp_q.push_back(4'h8);
        send(8'hF0); send(8'h1D); exp_q.push_back(4'h0);
        send(8'h1D); exp_q.push_back(4'h8);
        send(8'hF0); send(8'h1D);
        idle(2);
        chk("ovf_set", evt_overflow, 1);
        chk("ovf_valid", evt_valid, 1);
        send(8'h1D);
        evt_ready = 1'b1;
        chk("full_pop", evt_data, exp_q.pop_front());
        exp_q.push_back(4'h8);
        @(negedge CLOCK_50) evt_ready = 1'b0;
        drain();
        chk("ovf_sticky", evt_overflow, 1);

        // reset mid-sequence with keys held and FIFO non-empty
        send(8'h1C);
        idle(1);
        send(8'hE0); send(8'hF0);
        @(negedge CLOCK_50) rst = 1'b1;
        #1;
        chk("mrst_held", key_held, 0);
        chk("mrst_press", key_press, 0);
        chk("mrst_release", key_release, 0);
        chk("mrst_valid", evt_valid, 0);
        chk("mrst_data", evt_data, 0);
        chk("mrst_ovf", evt_overflow, 0);
        exp_q.delete();
        @(negedge CLOCK_50) rst = 1'b0;
        send(8'h75);
        chk("post_rst_75", key_held, 0);
        idle(3);
        chk("post_rst_valid", evt_valid, 0);
        send(8'hE0);
        @(negedge CLOCK_50) rst = 1'b1;
        @(negedge CLOCK_50) rst = 1'b0;
        send(8'h75);
        chk("post_rst_e0_75", key_held, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
